// File: rtl/acc_pkg.sv
// Shared encodings for the accumulator CPU memory stage: source selects and FSM states.
package acc_pkg;

  localparam logic [1:0] ASEL_PC  = 2'd0;
  localparam logic [1:0] ASEL_IMM = 2'd1;
  localparam logic [1:0] ASEL_RA  = 2'd2;
  localparam logic [1:0] ASEL_ALU = 2'd3;

  localparam logic DSEL_ACC = 1'b0;
  localparam logic DSEL_PC  = 1'b1;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_RWAIT = 3'd1;
  localparam state_t S_RWR   = 3'd2;
  localparam state_t S_IORD  = 3'd3;
  localparam state_t S_IOWR  = 3'd4;
  localparam state_t S_DONE  = 3'd5;

endpackage

// File: rtl/acc_sync_ram.sv
// Single-port RAM with registered read; a write also returns the written word (write-first).
module acc_sync_ram #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/acc_mem_unit.sv
// Memory stage: address/data muxing, RAM with read wait states, one memory-mapped IO word,
// and the IR/MDR registers behind a request/response handshake.
module acc_mem_unit
  import acc_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 16,
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] RA_ADDR    = 'h3FE,
  parameter logic [ADDR_WIDTH-1:0] IO_ADDR    = 'h3FF,
  parameter int unsigned           RD_LATENCY = 1
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            addr_sel,
  input  logic                  data_sel,
  input  logic                  ir_write,
  input  logic [DATA_WIDTH-1:0] PC,
  input  logic [DATA_WIDTH-1:0] IR_imm,
  input  logic [DATA_WIDTH-1:0] ALUOut,
  input  logic [DATA_WIDTH-1:0] ACC,
  output logic [DATA_WIDTH-1:0] IROut,
  output logic [DATA_WIDTH-1:0] MDROut,
  output logic                  rsp_valid,
  input  logic [DATA_WIDTH-1:0] IOIn,
  input  logic                  io_in_valid,
  output logic                  io_in_ready,
  output logic [DATA_WIDTH-1:0] IOOut,
  output logic                  io_out_valid,
  input  logic                  io_out_ready
);

  localparam int unsigned CNT_W = $clog2(RD_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY - 1);

  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("acc_mem_unit: RD_LATENCY must be within 1..4");
  end
  if (DATA_WIDTH <= ADDR_WIDTH) begin : g_bad_width
    $error("acc_mem_unit: DATA_WIDTH must exceed ADDR_WIDTH");
  end

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  irw_q, irw_d;
  logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [DATA_WIDTH-1:0] ioout_q, ioout_d;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  accept;
  logic                  is_io;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic                  ram_re;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  unused_hi;

  // Upper source bits are deliberately dropped: addresses wrap modulo the RAM depth.
  assign unused_hi = ^{PC[DATA_WIDTH-1:ADDR_WIDTH], IR_imm[DATA_WIDTH-1:ADDR_WIDTH],
                       ALUOut[DATA_WIDTH-1:ADDR_WIDTH]};

  always_comb begin
    sel_addr = '0;
    case (addr_sel)
      ASEL_PC:  sel_addr = PC[ADDR_WIDTH-1:0];
      ASEL_IMM: sel_addr = IR_imm[ADDR_WIDTH-1:0];
      ASEL_RA:  sel_addr = RA_ADDR;
      ASEL_ALU: sel_addr = ALUOut[ADDR_WIDTH-1:0];
      default:  sel_addr = '0;
    endcase
  end

  assign sel_data = (data_sel == DSEL_PC) ? PC : ACC;
  assign accept   = req_valid & req_ready;
  assign is_io    = (sel_addr == IO_ADDR);

  // RAM is only enabled on the accept edge; while waiting, its read register holds the word.
  assign ram_addr = (state_q == S_IDLE) ? sel_addr : addr_q;
  assign ram_we   = accept & req_write & ~is_io;
  assign ram_re   = accept & ~req_write & ~is_io;

  acc_sync_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (CLK),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wdata(sel_data),
    .rdata(ram_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    irw_d   = irw_q;
    mdr_d   = mdr_q;
    ir_d    = ir_q;
    ioout_d = ioout_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d = sel_addr;
          irw_d  = ir_write;
          cnt_d  = '0;
          if (is_io) begin
            if (req_write) begin
              ioout_d = sel_data;
              state_d = S_IOWR;
            end else begin
              state_d = S_IORD;
            end
          end else begin
            state_d = req_write ? S_RWR : S_RWAIT;
          end
        end
      end
      S_RWAIT: begin
        if (cnt_q == CNT_LAST) begin
          mdr_d = ram_q;
          if (irw_q) ir_d = ram_q;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RWR:  state_d = S_IDLE;
      S_IORD: begin
        if (io_in_valid) begin
          mdr_d = IOIn;
          if (irw_q) ir_d = IOIn;
          state_d = S_DONE;
        end
      end
      S_IOWR: begin
        if (io_out_ready) state_d = S_IDLE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      irw_q   <= 1'b0;
      mdr_q   <= '0;
      ir_q    <= '0;
      ioout_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      irw_q   <= irw_d;
      mdr_q   <= mdr_d;
      ir_q    <= ir_d;
      ioout_q <= ioout_d;
    end
  end

  // Completion states keep req_ready low, so it rises only the cycle after rsp_valid.
  assign req_ready    = (state_q == S_IDLE);
  assign io_in_ready  = (state_q == S_IORD);
  assign io_out_valid = (state_q == S_IOWR);
  assign rsp_valid    = (state_q == S_RWR) || (state_q == S_DONE) ||
                        ((state_q == S_IOWR) && io_out_ready);
  assign IROut        = ir_q;
  assign MDROut       = mdr_q;
  assign IOOut        = ioout_q;

endmodule

// File: tb/tb_acc_mem_unit.sv
// Scoreboard bench: two memory units (read latency 1 and 4) share stimulus; monitors check responses.
module tb_acc_mem_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        req_valid, req_write, data_sel, ir_write;
  logic [1:0]  addr_sel;
  logic [15:0] PC, IR_imm, ALUOut, ACC, IOIn;
  logic        io_in_valid, io_out_ready;

  logic        a_rdy, a_rsp, a_iir, a_iov;
  logic [15:0] a_ir, a_mdr, a_ioout;
  logic        b_rdy, b_rsp, b_iir, b_iov;
  logic [15:0] b_ir, b_mdr, b_ioout;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  typedef struct {
    int          id;
    bit          load;
    logic [15:0] mdr;
    logic [15:0] ir;
    int          acc;
    int          lat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  acc_mem_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .RD_LATENCY(1)) u_a (
    .CLK(CLK), .Reset(Reset), .req_valid(req_valid), .req_ready(a_rdy),
    .req_write(req_write), .addr_sel(addr_sel), .data_sel(data_sel), .ir_write(ir_write),
    .PC(PC), .IR_imm(IR_imm), .ALUOut(ALUOut), .ACC(ACC),
    .IROut(a_ir), .MDROut(a_mdr), .rsp_valid(a_rsp),
    .IOIn(IOIn), .io_in_valid(io_in_valid), .io_in_ready(a_iir),
    .IOOut(a_ioout), .io_out_valid(a_iov), .io_out_ready(io_out_ready)
  );

  acc_mem_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .RD_LATENCY(4)) u_b (
    .CLK(CLK), .Reset(Reset), .req_valid(req_valid), .req_ready(b_rdy),
    .req_write(req_write), .addr_sel(addr_sel), .data_sel(data_sel), .ir_write(ir_write),
    .PC(PC), .IR_imm(IR_imm), .ALUOut(ALUOut), .ACC(ACC),
    .IROut(b_ir), .MDROut(b_mdr), .rsp_valid(b_rsp),
    .IOIn(IOIn), .io_in_valid(io_in_valid), .io_in_ready(b_iir),
    .IOOut(b_ioout), .io_out_valid(b_iov), .io_out_ready(io_out_ready)
  );

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  always @(negedge CLK) begin : mon_a
    exp_t e;
    if (Reset === 1'b1 && a_rsp === 1'b1) begin
      if (qa.size() == 0) begin
        n_chk++;
        $display("FAIL A unexpected rsp_valid: got 1 expected 0 at cycle %0d", cyc);
      end else begin
        e = qa.pop_front();
        chk($sformatf("A id%0d req_ready during rsp", e.id), 16'(a_rdy), 16'd0);
        if (e.lat > 0) chk($sformatf("A id%0d latency", e.id), 16'(cyc - e.acc + 1), 16'(e.lat));
        if (e.load) begin
          chk($sformatf("A id%0d MDROut", e.id), a_mdr, e.mdr);
          chk($sformatf("A id%0d IROut", e.id), a_ir, e.ir);
        end
      end
    end
  end

  always @(negedge CLK) begin : mon_b
    exp_t e;
    if (Reset === 1'b1 && b_rsp === 1'b1) begin
      if (qb.size() == 0) begin
        n_chk++;
        $display("FAIL B unexpected rsp_valid: got 1 expected 0 at cycle %0d", cyc);
      end else begin
        e = qb.pop_front();
        chk($sformatf("B id%0d req_ready during rsp", e.id), 16'(b_rdy), 16'd0);
        if (e.lat > 0) chk($sformatf("B id%0d latency", e.id), 16'(cyc - e.acc + 1), 16'(e.lat));
        if (e.load) begin
          chk($sformatf("B id%0d MDROut", e.id), b_mdr, e.mdr);
          chk($sformatf("B id%0d IROut", e.id), b_ir, e.ir);
        end
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (!(a_rdy === 1'b1 && b_rdy === 1'b1) && t < 100) begin
      @(posedge CLK); #1;
      t++;
    end
    if (t >= 100) begin
      n_chk++;
      $display("FAIL wait_idle: req_ready got %b/%b expected 1/1 within 100 cycles", a_rdy, b_rdy);
    end
  endtask

  task automatic issue(input int id, input bit push, input logic wr, input logic [1:0] asel,
                       input logic dsel, input logic irw, input logic [15:0] pc,
                       input logic [15:0] imm, input logic [15:0] alu, input logic [15:0] acc,
                       input bit ld, input logic [15:0] emdr, input logic [15:0] eir,
                       input int lat_a, input int lat_b);
    exp_t e;
    wait_idle();
    req_write = wr; addr_sel = asel; data_sel = dsel; ir_write = irw;
    PC = pc; IR_imm = imm; ALUOut = alu; ACC = acc;
    e.id = id; e.load = ld; e.mdr = emdr; e.ir = eir; e.acc = cyc + 1;
    if (push) begin
      e.lat = lat_a; qa.push_back(e);
      e.lat = lat_b; qb.push_back(e);
    end
    req_valid = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    PC = 16'hDEAD; IR_imm = 16'hDEAD; ALUOut = 16'hDEAD; ACC = 16'hDEAD;
  endtask

  initial begin
    Reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; addr_sel = 2'd0; data_sel = 1'b0;
    ir_write = 1'b0; PC = '0; IR_imm = '0; ALUOut = '0; ACC = '0; IOIn = '0;
    io_in_valid = 1'b0; io_out_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("A reset IROut", a_ir, 16'h0);       chk("B reset IROut", b_ir, 16'h0);
    chk("A reset MDROut", a_mdr, 16'h0);     chk("B reset MDROut", b_mdr, 16'h0);
    chk("A reset IOOut", a_ioout, 16'h0);    chk("A reset rsp_valid", 16'(a_rsp), 16'h0);
    chk("A reset io_in_ready", 16'(a_iir), 16'h0);
    chk("A reset io_out_valid", 16'(a_iov), 16'h0);
    Reset = 1'b1;
    @(posedge CLK); #1;
    chk("A req_ready after reset", 16'(a_rdy), 16'h1);
    chk("B req_ready after reset", 16'(b_rdy), 16'h1);

    issue(1, 1, 1'b1, 2'd3, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0012, 16'hBEEF, 0, '0, '0, 1, 1);
    issue(2, 1, 1'b1, 2'd1, 1'b0, 1'b0, 16'h0, 16'h0000, 16'h0, 16'h1234, 0, '0, '0, 1, 1);
    issue(3, 1, 1'b0, 2'd3, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0012, 16'h0, 1, 16'hBEEF, 16'h0, 2, 5);
    issue(4, 1, 1'b0, 2'd3, 1'b0, 1'b0, 16'h0, 16'h0, 16'hFC12, 16'h0, 1, 16'hBEEF, 16'h0, 2, 5);
    issue(5, 1, 1'b0, 2'd0, 1'b0, 1'b1, 16'h0400, 16'h0, 16'h0, 16'h0, 1, 16'h1234, 16'h1234, 2, 5);
    issue(6, 1, 1'b1, 2'd2, 1'b1, 1'b0, 16'h0123, 16'h0, 16'h0, 16'h5555, 0, '0, '0, 1, 1);
    issue(7, 1, 1'b0, 2'd2, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1, 16'h0123, 16'h1234, 2, 5);

    io_out_ready = 1'b0;
    issue(8, 1, 1'b1, 2'd1, 1'b0, 1'b0, 16'h0, 16'h03FF, 16'h0, 16'hCAFE, 0, '0, '0, -1, -1);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("A io_out_valid stalled", 16'(a_iov), 16'h1);
      chk("B io_out_valid stalled", 16'(b_iov), 16'h1);
      chk("A IOOut stalled", a_ioout, 16'hCAFE);
      chk("A req_ready stalled", 16'(a_rdy), 16'h0);
      chk("B req_ready stalled", 16'(b_rdy), 16'h0);
    end
    @(posedge CLK); #1;
    io_out_ready = 1'b1;
    @(posedge CLK); #1;
    io_out_ready = 1'b0;
    chk("A io_out_valid after handshake", 16'(a_iov), 16'h0);
    chk("A IOOut held", a_ioout, 16'hCAFE);
    chk("B IOOut held", b_ioout, 16'hCAFE);

    issue(9, 1, 1'b0, 2'd3, 1'b0, 1'b0, 16'h0, 16'h0, 16'h03FF, 16'h0, 1, 16'h00A5, 16'h1234, -1, -1);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("A io_in_ready waiting", 16'(a_iir), 16'h1);
      chk("B io_in_ready waiting", 16'(b_iir), 16'h1);
    end
    @(posedge CLK); #1;
    IOIn = 16'h00A5; io_in_valid = 1'b1;
    @(posedge CLK); #1;
    io_in_valid = 1'b0; IOIn = 16'h0;
    chk("A io_in_ready dropped", 16'(a_iir), 16'h0);
    chk("B io_in_ready dropped", 16'(b_iir), 16'h0);
    wait_idle();

    issue(10, 0, 1'b0, 2'd3, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0012, 16'h0, 1, '0, '0, 0, 0);
    @(negedge CLK);
    Reset = 1'b0;
    #1;
    chk("A abort MDROut", a_mdr, 16'h0);     chk("B abort MDROut", b_mdr, 16'h0);
    chk("A abort IROut", a_ir, 16'h0);       chk("B abort IROut", b_ir, 16'h0);
    chk("A abort IOOut", a_ioout, 16'h0);    chk("B abort IOOut", b_ioout, 16'h0);
    chk("A abort rsp_valid", 16'(a_rsp), 16'h0);
    chk("B abort rsp_valid", 16'(b_rsp), 16'h0);
    repeat (2) @(posedge CLK);
    #1;
    Reset = 1'b1;
    @(posedge CLK); #1;
    chk("A req_ready after abort", 16'(a_rdy), 16'h1);
    issue(11, 1, 1'b0, 2'd2, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1, 16'h0123, 16'h0, 2, 5);
    issue(12, 1, 1'b0, 2'd0, 1'b0, 1'b1, 16'h0000, 16'h0, 16'h0, 16'h0, 1, 16'h1234, 16'h1234, 2, 5);
    wait_idle();
    repeat (3) @(posedge CLK);
    #1;
    chk("A scoreboard drained", 16'(qa.size()), 16'h0);
    chk("B scoreboard drained", 16'(qb.size()), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
